// File: rtl/seg_glyph_painter.sv
// seg_glyph_painter: renders NUM_DIGITS packed 7-segment patterns as font glyphs.
// Each frame works from one snapshot of seg_in. For every digit, and for every
// glyph row inside that digit, it issues one font ROM address per cycle. A
// delay line of ROM_LATENCY+1 stages carries the matching framebuffer address,
// so each ROM byte leaves on fb_wdata together with its target address.

module seg_glyph_painter #(
   parameter int  NUM_DIGITS  = 4,
   parameter int  GLYPH_ROWS  = 16,
   parameter int  ROW_STRIDE  = 40,
   parameter int  DIGIT_PITCH = 2,
   parameter int  BASE_ADDR   = 0,
   parameter int  ADDR_W      = 32,
   parameter int  ROM_LATENCY = 1,
   localparam int ROW_W       = $clog2(GLYPH_ROWS),
   localparam int RA_W        = 7 + ROW_W
) (
   input  logic                    CLOCK_50,
   input  logic                    rst_n,
   input  logic [7*NUM_DIGITS-1:0] seg_in,
   input  logic                    refresh_req,
   input  logic                    auto_mode,
   output logic [RA_W-1:0]         rom_addr,
   input  logic [7:0]              rom_data,
   output logic                    fb_we,
   output logic [ADDR_W-1:0]       fb_waddr,
   output logic [7:0]              fb_wdata,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int L     = ROM_LATENCY;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                  state, state_nx;
   logic [7*NUM_DIGITS-1:0] snap, snap_nx;
   logic                    pending, pending_nx;
   logic [DIG_W-1:0]        digit, digit_nx;
   logic [ROW_W-1:0]        row, row_nx;
   logic                    issue;
   logic                    trigger;
   logic                    last_issue;
   logic                    pipe_empty;
   logic [6:0]              pattern_nx;
   logic [ADDR_W-1:0]       target_nx;

   // Delay line carrying "a write is due" plus its target address.
   logic [L:0]              pipe_vld;
   logic [ADDR_W-1:0]       pipe_addr [L+1];

   assign trigger    = refresh_req | pending | (auto_mode & (seg_in != snap));
   assign last_issue = (digit == DIG_W'(NUM_DIGITS - 1)) && (row == ROW_W'(GLYPH_ROWS - 1));
   assign pipe_empty = ~|pipe_vld;

   // Next-state logic: frame sequencing, snapshot capture and the issue counters.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can leave one
      // unassigned and infer a latch.
      state_nx   = state;
      snap_nx    = snap;
      pending_nx = pending;
      digit_nx   = digit;
      row_nx     = row;
      issue      = 1'b0;
      unique case (state)
         IDLE: begin
            if (trigger) begin
               snap_nx    = seg_in;
               pending_nx = 1'b0;
               digit_nx   = '0;
               row_nx     = '0;
               issue      = 1'b1;
               state_nx   = FETCH;
            end
         end
         FETCH: begin
            if (last_issue) begin
               state_nx = DRAIN;
            end else begin
               issue = 1'b1;
               if (row == ROW_W'(GLYPH_ROWS - 1)) begin
                  row_nx   = '0;
                  digit_nx = digit + DIG_W'(1);
               end else begin
                  row_nx = row + ROW_W'(1);
               end
            end
         end
         DRAIN: begin
            if (pipe_empty) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // A request that arrives during a frame is remembered. Several such
      // requests still produce only one extra frame.
      if (state != IDLE && refresh_req) pending_nx = 1'b1;
   end

   // Pattern and target address for the item being issued this edge.
   always_comb begin
      pattern_nx = snap_nx[7*digit_nx +: 7];
      target_nx  = ADDR_W'(BASE_ADDR)
                 + ADDR_W'(digit_nx) * ADDR_W'(DIGIT_PITCH)
                 + ADDR_W'(row_nx) * ADDR_W'(ROW_STRIDE);
   end

   // Sequencer state, snapshot, pending flag and issue counters.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         snap    <= '0;
         pending <= 1'b0;
         digit   <= '0;
         row     <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments. Every flop then
         // samples the values from before the edge, whatever order the
         // statements are written in.
         state   <= state_nx;
         snap    <= snap_nx;
         pending <= pending_nx;
         digit   <= digit_nx;
         row     <= row_nx;
      end
   end

   // Font ROM address. It changes only when an item is issued, so it holds its
   // last value between frames.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
      end else if (issue) begin
         rom_addr <= {pattern_nx, row_nx};
      end
   end

   // Delay line that aligns each target address with its ROM data.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         // NOTE: the address stages are reset too. They are a few flops, not a
         // RAM, and the reset keeps a stale address from ever reaching fb_waddr.
         for (int i = 0; i <= L; i++) pipe_addr[i] <= '0;
      end else begin
         pipe_vld     <= {pipe_vld[L-1:0], issue};
         pipe_addr[0] <= target_nx;
         for (int i = 1; i <= L; i++) pipe_addr[i] <= pipe_addr[i-1];
      end
   end

   // Framebuffer write port and status outputs, all registered.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         fb_we      <= 1'b0;
         fb_waddr   <= '0;
         fb_wdata   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         fb_we <= pipe_vld[L];
         if (pipe_vld[L]) begin
            fb_waddr <= pipe_addr[L];
            fb_wdata <= rom_data;
         end
         busy       <= (state_nx != IDLE);
         frame_done <= (state == DRAIN) && pipe_empty;
      end
   end

endmodule

// File: tb/tb_seg_glyph_painter.sv
// Testbench for seg_glyph_painter. Three instances run side by side on shared
// stimulus: the default parameters, ROM_LATENCY=3, and a single two-row digit at
// BASE_ADDR=100. A frame-level reference model, built from the timing rules,
// predicts every write, rom_addr, busy and frame_done cycle.

module tb_seg_glyph_painter;

   localparam int NCFG = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        refresh_req;
   logic        auto_mode;
   logic [27:0] seg_all;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          cyc;
      logic [31:0] addr;
      logic [7:0]  data;
   } exp_wr_t;

   typedef struct {
      int cyc;
      int ra;
   } exp_ra_t;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Font ROM contents. Config 1 returns the low byte of the address.
   function automatic logic [7:0] rom_fn(input int kind, input int a);
      int h;
      if (kind == 1) begin
         h = a;
      end else begin
         h = (a * 29) ^ (a >> 3);
      end
      return h[7:0];
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
      localparam int L    = (g == 1) ? 3 : 1;
      localparam int N    = (g == 2) ? 1 : 4;
      localparam int R    = (g == 2) ? 2 : 16;
      localparam int BASE = (g == 2) ? 100 : 0;
      localparam int W    = N * R;
      localparam int RA_W = 7 + $clog2(R);

      logic [7*N-1:0]  seg;
      logic [RA_W-1:0] rom_addr;
      logic [7:0]      rom_data;
      logic            fb_we;
      logic [31:0]     fb_waddr;
      logic [7:0]      fb_wdata;
      logic            busy;
      logic            frame_done;
      logic [7:0]      rom_pipe [L];

      assign seg      = seg_all[7*N-1:0];
      assign rom_data = rom_pipe[L-1];

      seg_glyph_painter #(
         .NUM_DIGITS (N),
         .GLYPH_ROWS (R),
         .ROW_STRIDE (40),
         .DIGIT_PITCH(2),
         .BASE_ADDR  (BASE),
         .ADDR_W     (32),
         .ROM_LATENCY(L)
      ) u_dut (
         .CLOCK_50   (clk),
         .rst_n      (rst_n),
         .seg_in     (seg),
         .refresh_req(refresh_req),
         .auto_mode  (auto_mode),
         .rom_addr   (rom_addr),
         .rom_data   (rom_data),
         .fb_we      (fb_we),
         .fb_waddr   (fb_waddr),
         .fb_wdata   (fb_wdata),
         .busy       (busy),
         .frame_done (frame_done)
      );

      // Model font ROM: data appears L cycles after the address.
      always @(posedge clk) begin
         rom_pipe[0] <= rom_fn(g, int'(rom_addr));
         for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
      end

      // Reference model. cyc is the number of edges seen so far; the cycle
      // after edge e is cycle e.
      int         cyc         = 0;
      int         next_accept = 0;
      int         busy_lo     = 0;
      int         busy_hi     = -1;
      bit         pending     = 1'b0;
      logic [7*N-1:0] snap    = '0;
      exp_wr_t    wq[$];
      exp_ra_t    rq[$];
      int         dq[$];
      exp_wr_t    w_tmp;
      exp_ra_t    r_tmp;
      int         n_writes    = 0;
      int         n_frames    = 0;
      int         pend_total  = 0;
      bit         exp_we, exp_done, exp_busy;

      always @(posedge clk) begin
         cyc++;
         if (!rst_n) begin
            wq.delete();
            rq.delete();
            dq.delete();
            pending     = 1'b0;
            snap        = '0;
            next_accept = 0;
            busy_lo     = 0;
            busy_hi     = -1;
         end else if (cyc >= next_accept &&
                      (refresh_req || pending || (auto_mode && (seg != snap)))) begin
            snap    = seg;
            pending = 1'b0;
            for (int d = 0; d < N; d++) begin
               for (int r = 0; r < R; r++) begin
                  int k, pat;
                  k          = d * R + r;
                  pat        = int'(snap[7*d +: 7]);
                  r_tmp.cyc  = cyc + k;
                  r_tmp.ra   = pat * R + r;
                  rq.push_back(r_tmp);
                  w_tmp.cyc  = cyc + 1 + L + k;
                  w_tmp.addr = 32'(BASE + d * 2 + r * 40);
                  w_tmp.data = rom_fn(g, pat * R + r);
                  wq.push_back(w_tmp);
               end
            end
            dq.push_back(cyc + 1 + L + W);
            busy_lo     = cyc;
            busy_hi     = cyc + L + W;
            next_accept = cyc + L + W + 2;
         end else if (cyc < next_accept && refresh_req) begin
            pending = 1'b1;
         end
      end

      // Compare the DUT outputs with the model once per cycle, away from the edge.
      always @(negedge clk) begin
         if (!rst_n) begin
            check($sformatf("cfg%0d_reset_outputs", g),
                  64'({fb_we, busy, frame_done, fb_waddr, fb_wdata, rom_addr}), 64'd0);
         end else begin
            exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
            check($sformatf("cfg%0d_fb_we@%0d", g, cyc), 64'(fb_we), 64'(exp_we));
            if (exp_we) begin
               check($sformatf("cfg%0d_fb_waddr@%0d", g, cyc), 64'(fb_waddr), 64'(wq[0].addr));
               check($sformatf("cfg%0d_fb_wdata@%0d", g, cyc), 64'(fb_wdata), 64'(wq[0].data));
               void'(wq.pop_front());
            end
            if (fb_we) n_writes++;
            exp_done = (dq.size() > 0) && (dq[0] == cyc);
            check($sformatf("cfg%0d_frame_done@%0d", g, cyc), 64'(frame_done), 64'(exp_done));
            if (exp_done) void'(dq.pop_front());
            if (frame_done) n_frames++;
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            check($sformatf("cfg%0d_busy@%0d", g, cyc), 64'(busy), 64'(exp_busy));
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
               check($sformatf("cfg%0d_rom_addr@%0d", g, cyc), 64'(rom_addr), 64'(rq[0].ra));
               void'(rq.pop_front());
            end
         end
         pend_total = wq.size() + rq.size() + dq.size();
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse_refresh();
      refresh_req = 1'b1;
      tick(1);
      refresh_req = 1'b0;
   endtask

   // Watchdog: the stimulus below is far shorter than this.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int f0, f1, f2, base, waited;
      rst_n       = 1'b0;
      refresh_req = 1'b0;
      auto_mode   = 1'b0;
      seg_all     = {4{7'h3F}};
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // Single requested frame, pattern 7'h3F in every digit.
      pulse_refresh();
      tick(80);
      check("single_frame_writes_cfg0", 64'(gen_cfg[0].n_writes), 64'd64);
      check("single_frame_done_cfg0",   64'(gen_cfg[0].n_frames), 64'd1);
      check("single_frame_writes_cfg1", 64'(gen_cfg[1].n_writes), 64'd64);
      check("single_frame_done_cfg1",   64'(gen_cfg[1].n_frames), 64'd1);
      check("single_frame_writes_cfg2", 64'(gen_cfg[2].n_writes), 64'd2);
      check("single_frame_done_cfg2",   64'(gen_cfg[2].n_frames), 64'd1);

      // Three requests during one frame collapse into a single extra frame.
      f0 = gen_cfg[0].n_frames;
      f1 = gen_cfg[1].n_frames;
      f2 = gen_cfg[2].n_frames;
      pulse_refresh();
      tick(9);
      pulse_refresh();
      tick(9);
      pulse_refresh();
      tick(9);
      pulse_refresh();
      tick(200);
      check("collapse_frames_cfg0", 64'(gen_cfg[0].n_frames - f0), 64'd2);
      check("collapse_frames_cfg1", 64'(gen_cfg[1].n_frames - f1), 64'd2);
      check("short_frames_cfg2",    64'(gen_cfg[2].n_frames - f2), 64'd4);

      // Auto mode: digit 2 changes from 7'h06 to 7'h5B during the first frame.
      f0 = gen_cfg[0].n_frames;
      f1 = gen_cfg[1].n_frames;
      f2 = gen_cfg[2].n_frames;
      seg_all   = {7'h3F, 7'h06, 7'h4F, 7'h66};
      auto_mode = 1'b1;
      tick(30);
      seg_all[20:14] = 7'h5B;
      tick(200);
      check("auto_frames_cfg0", 64'(gen_cfg[0].n_frames - f0), 64'd2);
      check("auto_frames_cfg1", 64'(gen_cfg[1].n_frames - f1), 64'd2);
      check("auto_frames_cfg2", 64'(gen_cfg[2].n_frames - f2), 64'd1);
      auto_mode = 1'b0;

      // Reset asserted at write 20 aborts the frame.
      f0 = gen_cfg[0].n_frames;
      f1 = gen_cfg[1].n_frames;
      base = gen_cfg[0].n_writes;
      pulse_refresh();
      waited = 0;
      while (gen_cfg[0].n_writes < base + 20 && waited < 100) begin
         tick(1);
         waited++;
      end
      check("reach_write20", 64'(gen_cfg[0].n_writes >= base + 20), 64'd1);
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      f2 = gen_cfg[2].n_frames;
      tick(100);
      check("abort_no_done_cfg0", 64'(gen_cfg[0].n_frames), 64'(f0));
      check("abort_no_done_cfg1", 64'(gen_cfg[1].n_frames), 64'(f1));
      check("idle_after_reset_cfg2", 64'(gen_cfg[2].n_frames), 64'(f2));

      // After reset the snapshot is zero, so a nonzero seg_in in auto mode
      // starts a frame straight away.
      auto_mode = 1'b1;
      tick(100);
      check("auto_after_reset_cfg0", 64'(gen_cfg[0].n_frames - f0), 64'd1);
      auto_mode = 1'b0;

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         refresh_req = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 59) == 0) seg_all[7*$urandom_range(0, 3) +: 7] = 7'($urandom);
         if ($urandom_range(0, 299) == 0) auto_mode = ~auto_mode;
         tick(1);
      end
      refresh_req = 1'b0;
      auto_mode   = 1'b0;
      tick(200);
      check("drained_cfg0", 64'(gen_cfg[0].pend_total), 64'd0);
      check("drained_cfg1", 64'(gen_cfg[1].pend_total), 64'd0);
      check("drained_cfg2", 64'(gen_cfg[2].pend_total), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_glyph_painter.md
# seg_glyph_painter

Parametrised renderer that turns NUM_DIGITS packed 7-segment patterns into font glyphs in the LCD framebuffer. It sits between the MIPS system's HEX outputs and the font ROM / framebuffer write port, replacing free-running scan glue. It adds a snapshot-consistent frame sequencer with a latency-aligned write pipeline, on-demand and on-change refresh, and busy/done status.

## Interface
- NUM_DIGITS, 4: digits rendered per frame (1..16).
- GLYPH_ROWS, 16: rows per glyph; power of two, 2..64.
- ROW_STRIDE, 40: framebuffer byte distance between glyph rows.
- DIGIT_PITCH, 2: framebuffer byte distance between adjacent digits.
- BASE_ADDR, 0: framebuffer address of digit 0, row 0.
- ADDR_W, 32: framebuffer address width.
- ROM_LATENCY, 1: font ROM cycles from address to data (1..4).
- CLOCK_50 input 1: sole clock, rising edge.
- rst_n input 1: asynchronous active-low reset.
- seg_in input 7*NUM_DIGITS: digit d pattern in seg_in[7d+6:7d].
- refresh_req input 1: request one frame; level sampled each cycle.
- auto_mode input 1: 1 = also start a frame whenever seg_in differs from the last snapshot.
- rom_addr output 7+log2(GLYPH_ROWS): font ROM address = pattern*GLYPH_ROWS + row.
- rom_data input 8: font ROM byte, valid ROM_LATENCY cycles after rom_addr.
- fb_we output 1: framebuffer write strobe.
- fb_waddr output ADDR_W: framebuffer write address.
- fb_wdata output 8: framebuffer write data.
- busy output 1: frame in progress.
- frame_done output 1: one-cycle pulse after the last write of a frame.

## Operation
- States: IDLE, FETCH, DRAIN. Reset forces IDLE. All outputs are registered and reset to 0. Snapshot, counters, pending flag and pipeline also reset to 0.
- Trigger = refresh_req | pending | (auto_mode & seg_in != snapshot).
- IDLE with trigger:
  - latch seg_in into snapshot;
  - clear pending;
  - digit = 0, row = 0;
  - go to FETCH.
- FETCH issues one ROM address per cycle, row inner, digit outer: (0,0),(0,1)..(0,R-1),(1,0)..(N-1,R-1).
  - Each issue pushes a valid bit and its target address through a delay line of ROM_LATENCY+1 stages.
  - Target address = BASE_ADDR + digit*DIGIT_PITCH + row*ROW_STRIDE, truncated to ADDR_W.
  - After issuing (N-1,R-1), go to DRAIN.
- DRAIN continues until the delay line empties.
  - In the cycle after the last write: pulse frame_done and return to IDLE.
- fb_wdata captures rom_data at the edge ending cycle (issue + ROM_LATENCY). fb_we and fb_waddr are aligned with it.
- rom_addr holds its last value outside FETCH.
- refresh_req while busy sets pending. Multiple requests collapse into one frame.
- seg_in changes during a frame do not affect that frame. In auto_mode, a mismatch re-triggers once back in IDLE.
- Reset mid-frame aborts immediately: no further writes and no frame_done.
  - Because the snapshot resets to 0, a nonzero seg_in in auto_mode triggers a frame right after reset.

## Timing
- L = ROM_LATENCY, W = NUM_DIGITS*GLYPH_ROWS.
- Edge E0 accepts the trigger. Cycles after E0 are numbered 1, 2, ...
- rom_addr for write k (0-based) is valid in cycle 1+k, for k = 0..W-1.
- fb_we is high in cycles 2+L .. 1+L+W, contiguous, one write per cycle.
- frame_done is high in cycle 2+L+W only.
- busy is high in cycles 1 .. 1+L+W and low in the frame_done cycle.
- A pending or auto trigger is accepted at the end of the frame_done cycle. Between frames busy drops for exactly one cycle.
- Frame period = W+L+2 cycles.

## Test plan
- Defaults; seg_in = {4{7'h3F}}; one-cycle refresh_req:
  - 64 writes, fb_we in cycles 3..66, frame_done in cycle 67;
  - first write has rom_addr 1008 and fb_waddr 0;
  - last write has fb_waddr 3*2+15*40 = 606;
  - each fb_wdata equals ROM content at its address.
- ROM_LATENCY = 3 with a model ROM returning the address's low byte: every fb_wdata matches its fb_waddr row/digit pairing; first fb_we in cycle 5.
- refresh_req pulsed three times mid-frame: exactly one extra frame; busy low for exactly one cycle between frames.
- auto_mode = 1:
  - change digit 2 from 7'h06 to 7'h5B mid-frame: current frame writes 7'h06 glyphs, next frame writes 7'h5B;
  - static seg_in then produces no further frames.
- Assert rst_n low at write 20: all outputs 0 within the reset; no frame_done; with auto_mode = 0 and no request, stays idle after release.
- NUM_DIGITS = 1, GLYPH_ROWS = 2, BASE_ADDR = 100: writes to 100 and 140, frame_done in cycle 5.
